control_unit: RTL and testbench



---
 rtl/control_unit_pkg.sv | 54 +++++
 rtl/control_unit_if.sv | 32 +++
 rtl/control_unit_edge_detect.sv | 19 +
 rtl/control_unit.sv | 121 ++++++++++++
 tb/tb_control_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/control_unit_pkg.sv
// Shared encodings for the teaching-CPU controller.
// CONTROL_UNIT_STEP_EN adds the single-step wait state.
package control_unit_pkg;

  localparam logic [2:0] OP_HALT  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_INPUT = 3'b101;
  localparam logic [2:0] OP_JZ    = 3'b110;
  localparam logic [2:0] OP_JPOS  = 3'b111;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_RAM = 2'b10;

  typedef enum logic [3:0] {
    S_START     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_LOAD      = 4'd3,
    S_STORE     = 4'd4,
    S_ADD       = 4'd5,
    S_SUB       = 4'd6,
    S_INPUT     = 4'd7,
    S_JZ        = 4'd8,
    S_JPOS      = 4'd9,
`ifdef CONTROL_UNIT_STEP_EN
    S_HALT      = 4'd10,
    S_STEP_WAIT = 4'd11
`else
    S_HALT      = 4'd10
`endif
  } state_t;

  function automatic state_t exec_state(
    input logic [2:0] op
  );
    state_t s;
    unique case (op)
      OP_HALT:  s = S_HALT;
      OP_LOAD:  s = S_LOAD;
      OP_STORE: s = S_STORE;
      OP_ADD:   s = S_ADD;
      OP_SUB:   s = S_SUB;
      OP_INPUT: s = S_INPUT;
      OP_JZ:    s = S_JZ;
      default:  s = S_JPOS;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Controller <-> datapath bundle: opcode/flags/Enter in,
// datapath controls and debug state out.
interface control_unit_if;

  logic [2:0] IR;
  logic       Aeq0;
  logic       Apos;
  logic       Enter;
  logic       IRload;
  logic       JMPmux;
  logic       PCload;
  logic       Meminst;
  logic       MemWr;
  logic       Aload;
  logic       Sub;
  logic [1:0] Asel;
  logic       Halt;
  logic [3:0] State;

  modport master (
    input  IR, Aeq0, Apos, Enter,
    output IRload, JMPmux, PCload, Meminst,
    output MemWr, Aload, Sub, Asel, Halt, State
  );

  modport slave (
    output IR, Aeq0, Apos, Enter,
    input  IRload, JMPmux, PCload, Meminst,
    input  MemWr, Aload, Sub, Asel, Halt, State
  );

endinterface

// File: rtl/control_unit_edge_detect.sv
// Rising-edge detector for operator strobes; the history
// register samples every cycle so a held level fires once.
module edge_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) prev <= 1'b0;
    else        prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute Moore controller for the 8-bit CPU.
// CONTROL_UNIT_STEP_EN adds Step and the STEP_WAIT state.
module control_unit
  import control_unit_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
`ifdef CONTROL_UNIT_STEP_EN
  input  logic Step,
`endif
  control_unit_if.master bus
);

`ifdef CONTROL_UNIT_STEP_EN
  localparam state_t RESUME = S_STEP_WAIT;
  logic step_rise;

  edge_detect u_step_ed (
    .Clock (Clock),
    .Reset (Reset),
    .d     (Step),
    .rise  (step_rise)
  );
`else
  localparam state_t RESUME = S_FETCH;
`endif

  state_t state;
  state_t nxt;
  logic   enter_rise;

  edge_detect u_enter_ed (
    .Clock (Clock),
    .Reset (Reset),
    .d     (bus.Enter),
    .rise  (enter_rise)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_START;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_START:  nxt = RESUME;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = exec_state(bus.IR);
      S_LOAD,
      S_STORE,
      S_ADD,
      S_SUB,
      S_JZ,
      S_JPOS:   nxt = RESUME;
      S_INPUT:  nxt = enter_rise ? RESUME : S_INPUT;
      S_HALT:   nxt = S_HALT;
`ifdef CONTROL_UNIT_STEP_EN
      S_STEP_WAIT:
        nxt = step_rise ? S_FETCH : S_STEP_WAIT;
`endif
      default:  nxt = S_START;
    endcase
  end

  // Outputs follow the state; only Aload/PCload look at
  // the edge and flag inputs within their own state.
  always_comb begin
    bus.IRload  = 1'b0;
    bus.JMPmux  = 1'b0;
    bus.PCload  = 1'b0;
    bus.Meminst = 1'b0;
    bus.MemWr   = 1'b0;
    bus.Aload   = 1'b0;
    bus.Sub     = 1'b0;
    bus.Asel    = ASEL_ALU;
    bus.Halt    = 1'b0;
    unique case (state)
      S_FETCH: begin
        bus.IRload = 1'b1;
        bus.PCload = 1'b1;
      end
      S_DECODE: bus.Meminst = 1'b1;
      S_LOAD: begin
        bus.Meminst = 1'b1;
        bus.Asel    = ASEL_RAM;
        bus.Aload   = 1'b1;
      end
      S_STORE: begin
        bus.Meminst = 1'b1;
        bus.MemWr   = 1'b1;
      end
      S_ADD: begin
        bus.Meminst = 1'b1;
        bus.Aload   = 1'b1;
      end
      S_SUB: begin
        bus.Meminst = 1'b1;
        bus.Sub     = 1'b1;
        bus.Aload   = 1'b1;
      end
      S_INPUT: begin
        bus.Asel  = ASEL_IN;
        bus.Aload = enter_rise;
      end
      S_JZ: begin
        bus.JMPmux = 1'b1;
        bus.PCload = bus.Aeq0;
      end
      S_JPOS: begin
        bus.JMPmux = 1'b1;
        bus.PCload = bus.Apos;
      end
      S_HALT: bus.Halt = 1'b1;
      default: ;
    endcase
  end

  assign bus.State = state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: reset, every opcode,
// Enter edge handling and HALT hold.
module tb_control_unit;

  localparam logic [9:0] O_NONE  = 10'b0000000000;
  localparam logic [9:0] O_FETCH = 10'b1010000000;
  localparam logic [9:0] O_DEC   = 10'b0001000000;
  localparam logic [9:0] O_LOAD  = 10'b0001010100;
  localparam logic [9:0] O_STORE = 10'b0001100000;
  localparam logic [9:0] O_ADD   = 10'b0001010000;
  localparam logic [9:0] O_SUB   = 10'b0001011000;
  localparam logic [9:0] O_IN    = 10'b0000000010;
  localparam logic [9:0] O_INLD  = 10'b0000010010;
  localparam logic [9:0] O_JMP   = 10'b0110000000;
  localparam logic [9:0] O_NOJMP = 10'b0100000000;
  localparam logic [9:0] O_HALT  = 10'b0000000001;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [9:0] outs;

  control_unit_if bus ();

`ifdef CONTROL_UNIT_STEP_EN
  logic step;
  control_unit dut (
    .Clock (clk),
    .Reset (rst_n),
    .Step  (step),
    .bus   (bus)
  );
`else
  control_unit dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );
`endif

  assign outs = {bus.IRload, bus.JMPmux, bus.PCload,
                 bus.Meminst, bus.MemWr, bus.Aload,
                 bus.Sub, bus.Asel, bus.Halt};

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_st(input string tag,
                        input logic [3:0] st,
                        input logic [9:0] o);
    chk({tag, "_state"}, {12'd0, bus.State}, {12'd0, st});
    chk({tag, "_outs"}, {6'd0, outs}, {6'd0, o});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_fetch(input string tag);
`ifdef CONTROL_UNIT_STEP_EN
    tick();
    chk_st({tag, "_wait"}, 4'd11, O_NONE);
    tick();
    chk_st({tag, "_wait2"}, 4'd11, O_NONE);
    step = 1'b1;
    #1;
    chk_st({tag, "_wait3"}, 4'd11, O_NONE);
    tick();
    step = 1'b0;
`else
    tick();
`endif
    chk_st({tag, "_fetch"}, 4'd1, O_FETCH);
  endtask

  task automatic run_instr(input string tag,
                           input logic [2:0] op,
                           input logic [3:0] st,
                           input logic [9:0] o);
    bus.IR = op;
    tick();
    chk_st({tag, "_dec"}, 4'd2, O_DEC);
    tick();
    chk_st({tag, "_exec"}, st, o);
    goto_fetch(tag);
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    checks = 0;
    errors = 0;
    bus.IR = 3'b101;
    bus.Aeq0 = 1'b0;
    bus.Apos = 1'b0;
    bus.Enter = 1'b0;
`ifdef CONTROL_UNIT_STEP_EN
    step = 1'b0;
`endif
    #12;
    chk_st("rst", 4'd0, O_NONE);
    rst_n = 1'b1;
    #1;
    chk_st("start", 4'd0, O_NONE);
    goto_fetch("boot");
    tick();
    chk_st("boot_dec", 4'd2, O_DEC);
    tick();
    chk_st("boot_in", 4'd7, O_IN);
    tick();
    chk_st("boot_in2", 4'd7, O_IN);
    rst_n = 1'b0;
    #1;
    chk_st("rst_mid_in", 4'd0, O_NONE);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_st("restart", 4'd0, O_NONE);
    goto_fetch("boot2");

    run_instr("load", 3'b001, 4'd3, O_LOAD);
    run_instr("add", 3'b011, 4'd5, O_ADD);
    run_instr("add2", 3'b011, 4'd5, O_ADD);
    run_instr("sub", 3'b100, 4'd6, O_SUB);
    bus.Aeq0 = 1'b1;
    run_instr("jz_t", 3'b110, 4'd8, O_JMP);
    bus.Aeq0 = 1'b0;
    bus.Apos = 1'b1;
    run_instr("jz_n", 3'b110, 4'd8, O_NOJMP);
    run_instr("jpos_t", 3'b111, 4'd9, O_JMP);
    bus.Apos = 1'b0;
    bus.Aeq0 = 1'b1;
    run_instr("jpos_n", 3'b111, 4'd9, O_NOJMP);
    run_instr("store", 3'b010, 4'd4, O_STORE);

    // Enter low five INPUT cycles, then a rising edge.
    bus.IR = 3'b101;
    tick();
    chk_st("in_dec", 4'd2, O_DEC);
    tick();
    chk_st("in_w0", 4'd7, O_IN);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk_st("in_w", 4'd7, O_IN);
    end
    bus.Enter = 1'b1;
    #1;
    chk_st("in_edge", 4'd7, O_INLD);
    goto_fetch("in");

    // Enter still high: must not count again.
    tick();
    chk_st("hold_dec", 4'd2, O_DEC);
    tick();
    chk_st("hold_in", 4'd7, O_IN);
    tick();
    chk_st("hold_in2", 4'd7, O_IN);
    bus.Enter = 1'b0;
    tick();
    chk_st("hold_in3", 4'd7, O_IN);
    bus.Enter = 1'b1;
    #1;
    chk_st("hold_edge", 4'd7, O_INLD);
    goto_fetch("hold");
    bus.Enter = 1'b0;

    bus.IR = 3'b000;
    tick();
    chk_st("halt_dec", 4'd2, O_DEC);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_st("halt", 4'd10, O_HALT);
      bus.IR = 3'(i);
      bus.Enter = i[0];
      bus.Aeq0 = i[1];
      bus.Apos = i[2];
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
